vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

Receive-side counterpart of the team's 640x480@60 VGA timing generator. It takes an hsync/vsync/RGB stream that is synchronous to the same 25 MHz pixel clock and rebuilds row/column coordinates and a pixel-valid strobe. It measures line and frame lengths, locks only after consecutive conforming frames, and flags timing errors. It serves loopback self-test of the display path and capture of externally generated video into the 8-bit computer's frame logic.

## Interface
- H_TOTAL, 800, clocks per line
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, active pixels per line
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch in lines
- V_ACTIVE, 480, active lines
- LOCK_FRAMES, 2, consecutive good frames required for lock
- H_SKEW, 0, extra clocks added to the active-window start for pipeline alignment
- clk_25m  in  1  pixel clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- in_hsy  in  1  horizontal sync, active high
- in_vsy  in  1  vertical sync, active high
- in_r, in_g, in_b  in  1 each  pixel colour
- row  out  12  active line index, 0..V_ACTIVE-1
- colum  out  12  active pixel index, 0..H_ACTIVE-1
- pix_valid  out  1  row/colum/pix_* are valid this cycle
- pix_r, pix_g, pix_b  out  1 each  colour aligned to row/colum
- line_start  out  1  one-cycle pulse on each detected hsync rise
- frame_start  out  1  one-cycle pulse on each frame origin
- locked  out  1  timing has been verified
- sync_err  out  1  one-cycle pulse on a timing violation
- h_meas  out  12  length of the last complete line
- v_meas  out  12  line count of the last complete frame

## Operation
- Input stage: in_hsy, in_vsy and in_r/g/b are each registered twice (q1, q2).
- hrise = hsy_q1 & ~hsy_q2. vrise is defined the same way.
- hcnt, 12 bit:
  - Cleared on hrise, otherwise incremented.
  - Saturates at 4095.
  - On hrise, h_meas <= hcnt+1.
- vpend is set by vrise.
- frame origin = hrise & (vpend | vrise):
  - vcnt <= 0, v_meas <= vcnt+1, vpend cleared, frame_start pulses.
  - A vrise that coincides with hrise makes the current line line 0.
  - A vrise that arrives mid-line takes effect at the next hrise.
- On other hrise cycles, vcnt increments, saturating at 4095.
- Active window:
  - hcnt in [H_SYNC+H_BP+H_SKEW, H_SYNC+H_BP+H_SKEW+H_ACTIVE)
  - vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE)
  - locked must be 1.
- Inside the window:
  - colum = hcnt - (H_SYNC+H_BP+H_SKEW)
  - row = vcnt - (V_SYNC+V_BP)
  - pix_* = registered colour from the same stage as hcnt.
  - row, colum and pix_* are registered outputs.
- Outside the window: pix_valid=0, pix_*=0, and row/colum hold their last value.
- Line error: hrise with h_meas ≠ H_TOTAL (the value being written), or hcnt reaching H_TOTAL+16 with no hrise (timeout).
- Frame error: frame origin with vcnt+1 ≠ V_TOTAL, or vcnt reaching V_TOTAL+8 (timeout).
- FSM states SEARCH, TRACK, LOCKED. goodcnt is 3 bit.
  - SEARCH: first frame origin → TRACK, goodcnt=0, frame_err=0.
  - TRACK: a line error sets frame_err. At each frame origin:
    - If no error in the frame and the frame check passes, goodcnt+1.
    - Otherwise goodcnt=0.
    - frame_err clears.
    - When goodcnt would reach LOCK_FRAMES → LOCKED.
  - LOCKED: any line error, frame error or timeout → sync_err pulse, SEARCH, goodcnt=0.
- locked = (state == LOCKED), registered.
- sync_err pulses only from LOCKED. Errors in TRACK silently reset goodcnt.

## Timing
- Reset: all outputs 0 (row, colum, h_meas, v_meas = 12'd0); state SEARCH; counters, vpend, goodcnt cleared.
- Reset mid-frame: the decoder restarts in SEARCH with no residual lock.
- Latency:
  - in_hsy to line_start: 2 clocks.
  - Pixel at in_* to pix_*: 3 clocks.
  - Syncs and colour share the same delay, so alignment is preserved.
- locked rises on the clock after the frame_start that completes LOCK_FRAMES good frames. With defaults, that is after the 3rd frame_start following reset.
- sync_err and the drop of locked occur in the same cycle, on the clock after the violating hrise, frame origin or timeout.
- Timeouts fire once. They do not re-fire until a new hrise or frame origin.

## Structure
- The shared package holds:
  - the 640x480 timing constants, which the timing generator also uses;
  - the FSM state encoding;
  - the 12-bit coordinate width.
- One natural sub-module, vga_edge_sync: a two-flop register plus rise detect, instantiated for hsync and vsync.

## Test plan
- Nominal 640x480 stream from the timing generator, 4 frames → locked=1 after the 3rd frame_start. With H_SKEW=0, the first pix_valid follows the 3rd frame_start with row=0, colum=0. The bench checks the exact cycle against the generator's first active pixel and sets H_SKEW from that measurement. h_meas=800, v_meas=525.
- Colour bar input while locked → pix_r/g/b toggle exactly at colum 80, 160, … 560.
- One line shortened to 799 clocks while locked → sync_err pulse, locked=0, h_meas=799. Relock after 2 further good frames.
- hsync stopped while locked → sync_err when hcnt reaches 816, locked=0, no further sync_err.
- vsync arriving mid-line vs coincident with hsync → frame_start on the next hrise vs the same hrise, and vcnt=0 on that line.
- Reset asserted mid-frame while locked → outputs 0 immediately. After release, lock requires 3 frame_starts again.

Source files
------------

// File: rtl/vga_sync_decoder_pkg.sv
// Shared definitions for the 640x480@60 video path: timing constants used by
// both the timing generator and the receive-side decoder, the decoder FSM
// encoding and the coordinate width.
package vga_sync_decoder_pkg;

    // Coordinate / measurement width used on every counter and output.
    localparam int COORD_W = 12;

    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t COORD_MAX = '1;

    // 640x480@60 timing, 25 MHz pixel clock.
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_TOTAL  = 525;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_ACTIVE = 480;

    // Consecutive conforming frames needed before the decoder trusts the stream.
    localparam int VGA_LOCK_FRAMES = 2;

    // Slack beyond the nominal line/frame length before a missing sync is
    // declared a timeout.
    localparam int H_TIMEOUT_SLACK = 16;
    localparam int V_TIMEOUT_SLACK = 8;

    // Decoder lock FSM.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    // Increment that sticks at the top of the coordinate range instead of wrapping.
    function automatic coord_t sat_inc(input coord_t value);
        if (value == COORD_MAX) begin
            return value;
        end
        return value + coord_t'(1);
    endfunction

endpackage

// File: rtl/vga_edge_sync.sv
// Two-flop input register with rising-edge detect between the two stages.
// The rise strobe is aligned with the second stage, so anything else that is
// also registered twice stays in step with it.
module vga_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic q1_reg;
    logic q2_reg;

    // Two register stages on the incoming sync level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_reg <= 1'b0;
            q2_reg <= 1'b0;
        end else begin
            q1_reg <= d;
            q2_reg <= q1_reg;
        end
    end

    assign rise = q1_reg & ~q2_reg;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder. Rebuilds row/column coordinates and a
// pixel-valid strobe from an hsync/vsync/RGB stream on the pixel clock,
// measures line and frame lengths, locks after consecutive conforming frames
// and pulses sync_err when a locked stream breaks timing.
module vga_sync_decoder
    import vga_sync_decoder_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int LOCK_FRAMES = VGA_LOCK_FRAMES,
    parameter int H_SKEW      = 0
) (
    input  logic               clk_25m,
    input  logic               rst_n,
    input  logic               in_hsy,
    input  logic               in_vsy,
    input  logic               in_r,
    input  logic               in_g,
    input  logic               in_b,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] colum,
    output logic               pix_valid,
    output logic               pix_r,
    output logic               pix_g,
    output logic               pix_b,
    output logic               line_start,
    output logic               frame_start,
    output logic               locked,
    output logic               sync_err,
    output logic [COORD_W-1:0] h_meas,
    output logic [COORD_W-1:0] v_meas
);

    // Window edges and timeout points, in counter units.
    localparam coord_t H_TOTAL_C   = coord_t'(H_TOTAL);
    localparam coord_t H_START_C   = coord_t'(H_SYNC + H_BP + H_SKEW);
    localparam coord_t H_END_C     = coord_t'(H_SYNC + H_BP + H_SKEW + H_ACTIVE);
    localparam coord_t H_TIMEOUT_C = coord_t'(H_TOTAL + H_TIMEOUT_SLACK);
    localparam coord_t V_TOTAL_C   = coord_t'(V_TOTAL);
    localparam coord_t V_START_C   = coord_t'(V_SYNC + V_BP);
    localparam coord_t V_END_C     = coord_t'(V_SYNC + V_BP + V_ACTIVE);
    localparam coord_t V_TIMEOUT_C = coord_t'(V_TOTAL + V_TIMEOUT_SLACK);
    localparam logic [3:0] LOCK_C  = 4'(LOCK_FRAMES);

    genvar gi;

    // ------------------------------------------------------------------
    // Input stage: syncs through edge detectors, colour through two flops
    // so that colour, hcnt and the rise strobes all refer to the same pixel.
    // ------------------------------------------------------------------
    logic [1:0] sync_in;
    logic [1:0] sync_rise;
    logic       hrise;
    logic       vrise;

    assign sync_in = {in_vsy, in_hsy};

    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            vga_edge_sync u_sync (
                .clk   (clk_25m),
                .rst_n (rst_n),
                .d     (sync_in[gi]),
                .rise  (sync_rise[gi])
            );
        end
    endgenerate

    assign hrise = sync_rise[0];
    assign vrise = sync_rise[1];

    logic [2:0] rgb_q1_reg;
    logic [2:0] rgb_q2_reg;

    // Colour delay line, matched to the sync edge detectors.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q1_reg <= 3'b000;
            rgb_q2_reg <= 3'b000;
        end else begin
            rgb_q1_reg <= {in_r, in_g, in_b};
            rgb_q2_reg <= rgb_q1_reg;
        end
    end

    // ------------------------------------------------------------------
    // Line / frame counters and measurements
    // ------------------------------------------------------------------
    coord_t hcnt_reg, hcnt_next;
    coord_t vcnt_reg, vcnt_next;
    coord_t h_meas_reg, h_meas_next;
    coord_t v_meas_reg, v_meas_next;
    logic   vpend_reg, vpend_next;
    logic   v_to_done_reg, v_to_done_next;

    logic   origin;
    coord_t h_len;
    coord_t v_len;
    logic   h_bad;
    logic   h_timeout;
    logic   line_err;
    logic   frame_bad;
    logic   v_timeout;
    logic   frame_evt_err;

    // A vsync rise only marks a frame once the next line begins; if it lands
    // on the same cycle as hsync, that very line becomes line 0.
    assign origin = hrise & (vpend_reg | vrise);

    // Lengths as they would be recorded on this cycle's hrise / origin.
    assign h_len = sat_inc(hcnt_reg);
    assign v_len = sat_inc(vcnt_reg);

    // hcnt passes the timeout value exactly once between hrises (it only
    // counts up or saturates far above), so equality gives a single pulse.
    assign h_bad     = hrise & (h_len != H_TOTAL_C);
    assign h_timeout = ~hrise & (hcnt_reg == H_TIMEOUT_C);
    assign line_err  = h_bad | h_timeout;

    // vcnt can sit at the timeout value for a whole line, so a flag keeps the
    // frame timeout to one pulse until the next frame origin.
    assign frame_bad     = origin & (v_len != V_TOTAL_C);
    assign v_timeout     = ~v_to_done_reg & (vcnt_reg == V_TIMEOUT_C);
    assign frame_evt_err = frame_bad | v_timeout;

    // Next-state logic for counters, pending-vsync flag and measurements.
    always_comb begin
        hcnt_next      = hcnt_reg;
        vcnt_next      = vcnt_reg;
        h_meas_next    = h_meas_reg;
        v_meas_next    = v_meas_reg;
        vpend_next     = vpend_reg;
        v_to_done_next = v_to_done_reg;

        if (hrise) begin
            hcnt_next   = '0;
            h_meas_next = h_len;
        end else begin
            hcnt_next = sat_inc(hcnt_reg);
        end

        if (origin) begin
            vcnt_next      = '0;
            v_meas_next    = v_len;
            vpend_next     = 1'b0;
            v_to_done_next = 1'b0;
        end else begin
            if (hrise) begin
                vcnt_next = sat_inc(vcnt_reg);
            end
            if (vrise) begin
                vpend_next = 1'b1;
            end
            if (v_timeout) begin
                v_to_done_next = 1'b1;
            end
        end
    end

    // Counter and measurement registers.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_reg      <= '0;
            vcnt_reg      <= '0;
            h_meas_reg    <= '0;
            v_meas_reg    <= '0;
            vpend_reg     <= 1'b0;
            v_to_done_reg <= 1'b0;
        end else begin
            hcnt_reg      <= hcnt_next;
            vcnt_reg      <= vcnt_next;
            h_meas_reg    <= h_meas_next;
            v_meas_reg    <= v_meas_next;
            vpend_reg     <= vpend_next;
            v_to_done_reg <= v_to_done_next;
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    sync_state_t state_reg, state_next;
    logic [2:0]  goodcnt_reg, goodcnt_next;
    logic        frame_err_reg, frame_err_next;
    logic        err_pulse;
    logic [3:0]  goodcnt_inc;

    assign goodcnt_inc = {1'b0, goodcnt_reg} + 4'd1;

    // Lock state register.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SEARCH;
            goodcnt_reg   <= 3'd0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            goodcnt_reg   <= goodcnt_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Lock transitions; errors while tracking only restart the good-frame
    // count, errors while locked are reported and drop back to searching.
    always_comb begin
        state_next     = state_reg;
        goodcnt_next   = goodcnt_reg;
        frame_err_next = frame_err_reg;
        err_pulse      = 1'b0;

        case (state_reg)
            SEARCH: begin
                if (origin) begin
                    state_next     = TRACK;
                    goodcnt_next   = 3'd0;
                    frame_err_next = 1'b0;
                end
            end

            TRACK: begin
                if (line_err | v_timeout) begin
                    frame_err_next = 1'b1;
                end
                if (origin) begin
                    frame_err_next = 1'b0;
                    if (!frame_err_reg && !line_err && !frame_bad) begin
                        goodcnt_next = goodcnt_inc[2:0];
                        if (goodcnt_inc >= LOCK_C) begin
                            state_next = LOCKED;
                        end
                    end else begin
                        goodcnt_next = 3'd0;
                    end
                end
            end

            LOCKED: begin
                if (line_err | frame_evt_err) begin
                    err_pulse      = 1'b1;
                    state_next     = SEARCH;
                    goodcnt_next   = 3'd0;
                    frame_err_next = 1'b0;
                end
            end

            default: begin
                state_next     = SEARCH;
                goodcnt_next   = 3'd0;
                frame_err_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic   locked_reg;
    logic   line_start_reg;
    logic   frame_start_reg;
    logic   sync_err_reg;
    logic   pix_valid_reg;
    coord_t row_reg;
    coord_t colum_reg;
    logic [2:0] pix_rgb_reg;

    logic h_in_win;
    logic v_in_win;
    logic in_win;

    assign h_in_win = (hcnt_reg >= H_START_C) && (hcnt_reg < H_END_C);
    assign v_in_win = (vcnt_reg >= V_START_C) && (vcnt_reg < V_END_C);
    assign in_win   = h_in_win & v_in_win & locked_reg;

    // Strobes and lock flag; lock drops on the same edge as sync_err.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            locked_reg      <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            sync_err_reg    <= 1'b0;
        end else begin
            locked_reg      <= (state_next == LOCKED);
            line_start_reg  <= hrise;
            frame_start_reg <= origin;
            sync_err_reg    <= err_pulse;
        end
    end

    // Coordinates and colour: live inside the active window, colour blanked
    // and coordinates held outside it.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid_reg <= 1'b0;
            row_reg       <= '0;
            colum_reg     <= '0;
            pix_rgb_reg   <= 3'b000;
        end else begin
            pix_valid_reg <= in_win;
            if (in_win) begin
                row_reg     <= vcnt_reg - V_START_C;
                colum_reg   <= hcnt_reg - H_START_C;
                pix_rgb_reg <= rgb_q2_reg;
            end else begin
                pix_rgb_reg <= 3'b000;
            end
        end
    end

    assign row         = row_reg;
    assign colum       = colum_reg;
    assign pix_valid   = pix_valid_reg;
    assign pix_r       = pix_rgb_reg[2];
    assign pix_g       = pix_rgb_reg[1];
    assign pix_b       = pix_rgb_reg[0];
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;
    assign locked      = locked_reg;
    assign sync_err    = sync_err_reg;
    assign h_meas      = h_meas_reg;
    assign v_meas      = v_meas_reg;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder. A reduced-size raster (84x16 clocks,
// 64x8 active) keeps frames short; the decoder's timeout slack and lock
// count are unchanged, so every behaviour scales directly from 640x480.
module tb_vga_sync_decoder;

    localparam int HT     = 84;
    localparam int HS     = 8;
    localparam int HBP    = 6;
    localparam int HA     = 64;
    localparam int VT     = 16;
    localparam int VS     = 2;
    localparam int VBP    = 3;
    localparam int VA     = 8;
    localparam int HSTART = HS + HBP;
    localparam int VSTART = VS + VBP;
    localparam int FRAME  = HT * VT;

    logic        clk_25m = 1'b0;
    logic        rst_n   = 1'b0;
    logic        in_hsy  = 1'b0;
    logic        in_vsy  = 1'b0;
    logic        in_r    = 1'b0;
    logic        in_g    = 1'b0;
    logic        in_b    = 1'b0;
    logic [11:0] row;
    logic [11:0] colum;
    logic        pix_valid;
    logic        pix_r;
    logic        pix_g;
    logic        pix_b;
    logic        line_start;
    logic        frame_start;
    logic        locked;
    logic        sync_err;
    logic [11:0] h_meas;
    logic [11:0] v_meas;

    vga_sync_decoder #(
        .H_TOTAL     (HT),
        .H_SYNC      (HS),
        .H_BP        (HBP),
        .H_ACTIVE    (HA),
        .V_TOTAL     (VT),
        .V_SYNC      (VS),
        .V_BP        (VBP),
        .V_ACTIVE    (VA),
        .LOCK_FRAMES (2),
        .H_SKEW      (0)
    ) dut (
        .clk_25m     (clk_25m),
        .rst_n       (rst_n),
        .in_hsy      (in_hsy),
        .in_vsy      (in_vsy),
        .in_r        (in_r),
        .in_g        (in_g),
        .in_b        (in_b),
        .row         (row),
        .colum       (colum),
        .pix_valid   (pix_valid),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .line_start  (line_start),
        .frame_start (frame_start),
        .locked      (locked),
        .sync_err    (sync_err),
        .h_meas      (h_meas),
        .v_meas      (v_meas)
    );

    always #20 clk_25m = ~clk_25m;

    int tests = 0;
    int fails = 0;

    // Generator state: (gh, gv) is the position driven on the next tick.
    int   cyc     = 0;
    int   gh      = 0;
    int   gv      = 0;
    int   cur_len = HT;
    logic short_req = 1'b0;
    logic hsy_kill  = 1'b0;
    logic vsy_mid   = 1'b0;
    logic prev_vsy  = 1'b0;

    // Event log, filled by sample().
    int          fs_cnt = 0;
    int          se_cnt = 0;
    int          last_fs_cyc = 0;
    int          last_ls_cyc = 0;
    int          last_se_cyc = 0;
    int          vr_cyc = 0;
    int          hr_cyc = 0;
    int          gen_first_cyc = 0;
    logic        fs_ls = 1'b0;
    logic        se_locked = 1'b0;
    logic        se_ls = 1'b0;
    logic [11:0] se_hmeas = '0;

    task automatic sample();
        if (frame_start) begin
            fs_cnt++;
            last_fs_cyc = cyc;
            fs_ls = line_start;
        end
        if (line_start) last_ls_cyc = cyc;
        if (sync_err) begin
            se_cnt++;
            last_se_cyc = cyc;
            se_locked = locked;
            se_ls = line_start;
            se_hmeas = h_meas;
        end
    endtask

    task automatic drive_gen();
        logic [2:0] bar;
        if (gh == 0) begin
            if (short_req && gv == 6) begin
                cur_len = HT - 1;
                short_req = 1'b0;
            end else begin
                cur_len = HT;
            end
        end
        in_hsy = !hsy_kill && (gh < HS);
        if (vsy_mid)
            in_vsy = (gv == VT - 1 && gh >= 40) || (gv == 0) || (gv == 1 && gh < 40);
        else
            in_vsy = (gv < VS);
        if (gh >= HSTART && gh < HSTART + HA && gv >= VSTART && gv < VSTART + VA)
            bar = 3'((gh - HSTART) / 8);
        else
            bar = 3'b000;
        in_r = bar[0];
        in_g = bar[1];
        in_b = bar[2];
        if (in_vsy && !prev_vsy) vr_cyc = cyc;
        prev_vsy = in_vsy;
        if (gh == 0 && in_hsy) hr_cyc = cyc;
        if (gh == HSTART && gv == VSTART) gen_first_cyc = cyc;
        gh++;
        if (gh >= cur_len) begin
            gh = 0;
            gv = (gv == VT - 1) ? 0 : gv + 1;
        end
    endtask

    // One clock: sample outputs 1 ns after the edge, then drive the next pixel.
    task automatic tick();
        @(posedge clk_25m);
        #1;
        cyc++;
        sample();
        drive_gen();
    endtask

    task automatic wait_fs(input int target, input string name);
        int n = 0;
        while (fs_cnt < target && n < 2 * FRAME * 2) begin
            tick();
            n++;
        end
        if (fs_cnt < target) begin
            tests++;
            fails++;
            $display("FAIL %s: frame_start timeout, got %0d pulses, required %0d", name, fs_cnt, target);
        end
    endtask

    task automatic wait_gen(input int line, input int px);
        int n = 0;
        while (!(gv == line && gh == px) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        if (!(gv == line && gh == px)) begin
            tests++;
            fails++;
            $display("FAIL wait_gen: generator at %0d/%0d, required %0d/%0d", gv, gh, line, px);
        end
    endtask

    task automatic wait_pv(input string name);
        int n = 0;
        while (!pix_valid && n < 2 * FRAME) begin
            tick();
            n++;
        end
        if (!pix_valid) begin
            tests++;
            fails++;
            $display("FAIL %s: pix_valid timeout, got 0, required 1", name);
        end
    endtask

    // Lock sequence after a reset release in mid-frame: locked stays low
    // through the 2nd frame_start and is high after the 3rd.
    task automatic check_relock(input string name);
        int base;
        base = fs_cnt;
        wait_fs(base + 2, name);
        repeat (5) tick();
        tests++;
        if (locked !== 1'b0) begin
            fails++;
            $display("FAIL %s_after_2: locked=%0b, required 0", name, locked);
        end
        wait_fs(base + 3, name);
        repeat (2) tick();
        tests++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL %s_after_3: locked=%0b, required 1", name, locked);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) tick();
        tests++;
        if ({locked, pix_valid, line_start, frame_start, sync_err, pix_r, pix_g, pix_b} !== 8'h00) begin
            fails++;
            $display("FAIL reset_flags: got %b, required 00000000",
                     {locked, pix_valid, line_start, frame_start, sync_err, pix_r, pix_g, pix_b});
        end
        tests++;
        if (row !== 12'd0 || colum !== 12'd0) begin
            fails++;
            $display("FAIL reset_coord: row=%0d colum=%0d, required 0 0", row, colum);
        end
        tests++;
        if (h_meas !== 12'd0 || v_meas !== 12'd0) begin
            fails++;
            $display("FAIL reset_meas: h_meas=%0d v_meas=%0d, required 0 0", h_meas, v_meas);
        end
        wait_gen(8, 20);
        rst_n = 1'b1;
        $display("[TB] reset released at cycle %0d", cyc);
    endtask

    task automatic test_lock();
        int n;
        check_relock("lock");
        tests++;
        if (h_meas !== 12'(HT) || v_meas !== 12'(VT)) begin
            fails++;
            $display("FAIL lock_meas: h_meas=%0d v_meas=%0d, required %0d %0d", h_meas, v_meas, HT, VT);
        end
        wait_pv("first_pix");
        tests++;
        if (row !== 12'd0 || colum !== 12'd0) begin
            fails++;
            $display("FAIL first_pix_coord: row=%0d colum=%0d, required 0 0", row, colum);
        end
        tests++;
        if (cyc - gen_first_cyc !== 3) begin
            fails++;
            $display("FAIL first_pix_latency: %0d clocks, required 3", cyc - gen_first_cyc);
        end
        n = 0;
        while (!line_start && n < 2 * HT) begin
            tick();
            n++;
        end
        tests++;
        if (cyc - hr_cyc !== 2) begin
            fails++;
            $display("FAIL line_start_latency: %0d clocks, required 2", cyc - hr_cyc);
        end
        $display("[TB] locked, first pixel at gen+%0d clocks", 3);
    endtask

    task automatic test_colour_bars();
        int n = 0;
        int mism = 0;
        int changes = 0;
        int badpos = 0;
        logic [2:0] prev = 3'b000;
        logic [2:0] cur;
        logic [2:0] expv;
        while (!(pix_valid && row == 12'd2 && colum == 12'd0) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        for (int i = 0; i < HA; i++) begin
            cur = {pix_b, pix_g, pix_r};
            expv = 3'(i / 8);
            if (!pix_valid || colum != 12'(i) || cur != expv) mism++;
            if (i > 0 && cur != prev) begin
                changes++;
                if (i % 8 != 0) badpos++;
            end
            prev = cur;
            tick();
        end
        tests++;
        if (mism !== 0) begin
            fails++;
            $display("FAIL bars_pixels: %0d wrong pixels, required 0", mism);
        end
        tests++;
        if (changes !== 7 || badpos !== 0) begin
            fails++;
            $display("FAIL bars_toggle: %0d toggles (%0d off-boundary), required 7 (0)", changes, badpos);
        end
        tests++;
        if (pix_valid !== 1'b0 || {pix_r, pix_g, pix_b} !== 3'b000) begin
            fails++;
            $display("FAIL blank_pix: valid=%0b rgb=%b, required 0 000", pix_valid, {pix_r, pix_g, pix_b});
        end
        tests++;
        if (colum !== 12'd63 || row !== 12'd2) begin
            fails++;
            $display("FAIL blank_hold: row=%0d colum=%0d, required 2 63", row, colum);
        end
        $display("[TB] colour bar line checked");
    endtask

    task automatic test_short_line();
        int se0;
        int n = 0;
        se0 = se_cnt;
        short_req = 1'b1;
        while (se_cnt == se0 && n < 2 * FRAME) begin
            tick();
            n++;
        end
        tests++;
        if (se_cnt !== se0 + 1) begin
            fails++;
            $display("FAIL short_err: %0d sync_err pulses, required 1", se_cnt - se0);
        end
        tests++;
        if (se_locked !== 1'b0 || se_ls !== 1'b1 || se_hmeas !== 12'(HT - 1)) begin
            fails++;
            $display("FAIL short_state: locked=%0b line_start=%0b h_meas=%0d, required 0 1 %0d",
                     se_locked, se_ls, se_hmeas, HT - 1);
        end
        check_relock("short_relock");
        tests++;
        if (se_cnt !== se0 + 1 || h_meas !== 12'(HT)) begin
            fails++;
            $display("FAIL short_after: sync_err pulses=%0d h_meas=%0d, required 1 %0d",
                     se_cnt - se0, h_meas, HT);
        end
        $display("[TB] short line handled, relocked");
    endtask

    task automatic test_hsync_stop();
        int se0;
        int ls_ref;
        int n = 0;
        wait_gen(7, 0);
        hsy_kill = 1'b1;
        se0 = se_cnt;
        ls_ref = last_ls_cyc;
        repeat (600) tick();
        tests++;
        if (se_cnt !== se0 + 1) begin
            fails++;
            $display("FAIL hstop_count: %0d sync_err pulses, required 1", se_cnt - se0);
        end
        tests++;
        if (last_se_cyc - ls_ref !== HT + 16 + 1 || se_locked !== 1'b0) begin
            fails++;
            $display("FAIL hstop_timing: err %0d clocks after line_start locked=%0b, required %0d 0",
                     last_se_cyc - ls_ref, se_locked, HT + 17);
        end
        wait_gen(gv, 0);
        hsy_kill = 1'b0;
        while (!locked && n < 5 * FRAME) begin
            tick();
            n++;
        end
        tests++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL hstop_relock: locked=%0b, required 1", locked);
        end
        $display("[TB] hsync stop timeout handled");
    endtask

    task automatic test_vsync_align();
        int se0;
        se0 = se_cnt;
        wait_gen(5, 0);
        vsy_mid = 1'b1;
        wait_fs(fs_cnt + 1, "vmid_fs");
        tests++;
        if (last_fs_cyc - vr_cyc !== HT - 40 + 2 || fs_ls !== 1'b1) begin
            fails++;
            $display("FAIL vmid_fs: %0d clocks after vsync line_start=%0b, required %0d 1",
                     last_fs_cyc - vr_cyc, fs_ls, HT - 38);
        end
        wait_pv("vmid_row");
        tests++;
        if (row !== 12'd0 || colum !== 12'd0) begin
            fails++;
            $display("FAIL vmid_row: row=%0d colum=%0d, required 0 0", row, colum);
        end
        wait_gen(5, 0);
        vsy_mid = 1'b0;
        wait_fs(fs_cnt + 1, "vco_fs");
        tests++;
        if (last_fs_cyc - vr_cyc !== 2 || fs_ls !== 1'b1) begin
            fails++;
            $display("FAIL vco_fs: %0d clocks after vsync line_start=%0b, required 2 1",
                     last_fs_cyc - vr_cyc, fs_ls);
        end
        wait_pv("vco_row");
        tests++;
        if (row !== 12'd0 || se_cnt !== se0 || locked !== 1'b1) begin
            fails++;
            $display("FAIL vco_row: row=%0d sync_err pulses=%0d locked=%0b, required 0 0 1",
                     row, se_cnt - se0, locked);
        end
        $display("[TB] vsync alignment checked");
    endtask

    task automatic test_reset_mid();
        wait_gen(8, 20);
        rst_n = 1'b0;
        #1;
        tests++;
        if (locked !== 1'b0 || pix_valid !== 1'b0 || row !== 12'd0 || colum !== 12'd0) begin
            fails++;
            $display("FAIL rmid_out: locked=%0b valid=%0b row=%0d colum=%0d, required 0 0 0 0",
                     locked, pix_valid, row, colum);
        end
        tests++;
        if (h_meas !== 12'd0 || v_meas !== 12'd0) begin
            fails++;
            $display("FAIL rmid_meas: h_meas=%0d v_meas=%0d, required 0 0", h_meas, v_meas);
        end
        repeat (10) tick();
        rst_n = 1'b1;
        check_relock("rmid_relock");
        $display("[TB] mid-frame reset recovered");
    endtask

    initial begin
        test_reset();
        test_lock();
        test_colour_bars();
        test_short_line();
        test_hsync_stop();
        test_vsync_align();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #(90000 * 40);
        $display("FAIL watchdog: simulation exceeded 90000 clocks, required to finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
